cla_serial_add_ctrl: RTL and testbench

Sequencer that performs a WIDTH-bit add or subtract by time-multiplexing one external 4-bit CLA slice (cla_adder_4bit), one nibble per clock, LSB first. It latches the operands, feeds each nibble and the rippled carry to the slice, and collects the sum nibbles. It reports carry, signed overflow and zero flags behind a start/busy/done handshake. It sits between the ALU control logic and a single shared cla_adder_4bit instance.

---
 rtl/cla_serial_add_ctrl_if.sv | 35 +++
 rtl/cla_serial_add_ctrl.sv | 124 ++++++++++++
 tb/tb_cla_serial_add_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cla_serial_add_ctrl_if.sv
// Handshake, operand/result and 4-bit slice bus between the ALU control,
// the serial add sequencer and the shared cla_adder_4bit instance.
interface cla_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_c0;
  logic [3:0]       add_s;
  logic             add_c4;

  // Sequencer side
  modport slave (
    input  start, sub, a, b, add_s, add_c4,
    output busy, done, result, carry_out, overflow, zero,
           add_a, add_b, add_c0
  );

  // ALU control / slice side
  modport master (
    output start, sub, a, b, add_s, add_c4,
    input  busy, done, result, carry_out, overflow, zero,
           add_a, add_b, add_c0
  );
endinterface

// File: rtl/cla_serial_add_ctrl.sv
// WIDTH-bit add/subtract performed one nibble per clock, LSB first, through a
// single external combinational 4-bit CLA slice.
module cla_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cla_serial_add_ctrl_if.slave bus
);
  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_nxt;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] result_q, result_nxt;
  logic             carry_reg;
  logic             carry_out_q, overflow_q, zero_q;
  logic             last_nib;
  logic             busy_c, done_c;
  logic [3:0]       add_a_c, add_b_c;
  logic             add_c0_c;

  assign last_nib = (idx_q == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_nib)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: slice is driven only while nibbles are in flight
  always_comb begin
    busy_c   = 1'b0;
    done_c   = 1'b0;
    add_a_c  = '0;
    add_b_c  = '0;
    add_c0_c = 1'b0;
    unique case (state_q)
      RUN: begin
        busy_c   = 1'b1;
        add_a_c  = a_reg[4*idx_q +: 4];
        add_b_c  = b_reg[4*idx_q +: 4];
        add_c0_c = carry_reg;
      end
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  // Result with the current slice sum merged in; flags are taken from this
  // on the final nibble so they are valid in the same cycle as done.
  always_comb begin
    result_nxt                = result_q;
    result_nxt[4*idx_q +: 4]  = bus.add_s;
  end

  // Operand latch, nibble capture and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      result_q    <= '0;
      carry_reg   <= 1'b0;
      idx_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_reg       <= bus.a;
            b_reg       <= bus.sub ? ~bus.b : bus.b;
            carry_reg   <= bus.sub;
            idx_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
          end
        end
        RUN: begin
          result_q  <= result_nxt;
          carry_reg <= bus.add_c4;
          if (last_nib) begin
            idx_q       <= '0;
            carry_out_q <= bus.add_c4;
            overflow_q  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                           (result_nxt[WIDTH-1] != a_reg[WIDTH-1]);
            zero_q      <= (result_nxt == '0);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
  assign bus.add_a     = add_a_c;
  assign bus.add_b     = add_b_c;
  assign bus.add_c0    = add_c0_c;
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Directed bench for cla_serial_add_ctrl with a behavioural 4-bit slice.
module tb_cla_serial_add_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  cla_serial_add_ctrl_if #(.WIDTH(16)) bus ();

  cla_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Combinational CLA slice model
  assign {bus.add_c4, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0000, bus.add_c0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one op and check it nibble by nibble through DONE and back to IDLE.
  task automatic run_op(input string name,
                        input logic [15:0] a_i, input logic [15:0] b_i, input logic sub_i,
                        input logic [15:0] exp_aseq, input logic [3:0] exp_c0seq,
                        input logic [3:0] exp_b0, input logic [15:0] exp_res,
                        input logic exp_c, input logic exp_v, input logic exp_z,
                        input bit inj_start);
    bus.a = a_i; bus.b = b_i; bus.sub = sub_i; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (inj_start && i == 2) bus.start = 1'b0;
      chk({name, "_busy"}, bus.busy, 1'b1);
      chk({name, "_done_run"}, bus.done, 1'b0);
      chk({name, "_add_a"}, bus.add_a, exp_aseq[4*i +: 4]);
      chk({name, "_add_c0"}, bus.add_c0, exp_c0seq[i]);
      if (i == 0) begin
        chk({name, "_add_b0"}, bus.add_b, exp_b0);
        chk({name, "_res_clr"}, bus.result, 16'h0000);
      end
      if (inj_start && i == 1) begin
        bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h1111;
      end
      step();
    end
    bus.start = 1'b0;
    chk({name, "_done"}, bus.done, 1'b1);
    chk({name, "_busy_done"}, bus.busy, 1'b0);
    chk({name, "_result"}, bus.result, exp_res);
    chk({name, "_carry"}, bus.carry_out, exp_c);
    chk({name, "_ovf"}, bus.overflow, exp_v);
    chk({name, "_zero"}, bus.zero, exp_z);
    chk({name, "_add_a_done"}, bus.add_a, 4'h0);
    step();
    chk({name, "_done_idle"}, bus.done, 1'b0);
    chk({name, "_busy_idle"}, bus.busy, 1'b0);
    chk({name, "_result_hold"}, bus.result, exp_res);
    chk({name, "_carry_hold"}, bus.carry_out, exp_c);
  endtask

  initial begin
    int done_cnt;
    int done_cyc[3];
    total = 0; bad = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    step();
    step();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_result", bus.result, 16'h0000);
    chk("rst_flags", {bus.carry_out, bus.overflow, bus.zero}, 3'b000);
    chk("rst_add", {bus.add_a, bus.add_b, bus.add_c0}, 9'h000);
    rst = 1'b0;
    step();
    chk("idle_busy", bus.busy, 1'b0);

    run_op("t1", 16'h1234, 16'h4321, 1'b0, 16'h1234, 4'b0000, 4'h1, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 4'b1110, 4'h1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("t3a", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 4'b1110, 4'h1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("t3b", 16'h8000, 16'h0001, 1'b1, 16'h8000, 4'b0001, 4'hE, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("t4", 16'h0005, 16'h0007, 1'b1, 16'h0005, 4'b0001, 4'h8, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("t5", 16'h1234, 16'h4321, 1'b0, 16'h1234, 4'b0000, 4'h1, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_second_busy", bus.busy, 1'b0);
      chk("t5_no_second_done", bus.done, 1'b0);
      step();
    end

    // Reset in the second RUN cycle aborts the op
    bus.a = 16'h00FF; bus.b = 16'h0001; bus.sub = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("t5r_busy_run", bus.busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5r_busy", bus.busy, 1'b0);
    chk("t5r_result", bus.result, 16'h0000);
    chk("t5r_add", {bus.add_a, bus.add_b, bus.add_c0}, 9'h000);
    chk("t5r_flags", {bus.carry_out, bus.overflow, bus.zero}, 3'b000);
    for (int i = 0; i < 6; i++) begin
      chk("t5r_no_done", bus.done, 1'b0);
      step();
    end

    // Continuous start: back-to-back ops every N+2 cycles
    bus.a = 16'h00FF; bus.b = 16'h0001; bus.sub = 1'b0; bus.start = 1'b1;
    step();
    done_cnt = 0;
    for (int c = 0; c < 40 && done_cnt < 3; c++) begin
      if (bus.done === 1'b1) begin
        done_cyc[done_cnt] = c;
        done_cnt++;
        chk("t6_result", bus.result, 16'h0100);
        chk("t6_carry", bus.carry_out, 1'b0);
        if (done_cnt == 3) bus.start = 1'b0;
      end
      step();
    end
    bus.start = 1'b0;
    chk("t6_done_count", done_cnt, 3);
    if (done_cnt == 3) begin
      chk("t6_first_done", done_cyc[0], 4);
      chk("t6_spacing1", done_cyc[1] - done_cyc[0], 6);
      chk("t6_spacing2", done_cyc[2] - done_cyc[1], 6);
    end
    step();
    chk("t6_idle_after", bus.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
